// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and code classifiers for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Bytes following E1 that belong to the pause sequence and are swallowed.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Controller responses (ACK, BAT OK, echo, resend, BAT fail) and overrun codes.
    localparam int unsigned PS2_NUM_DISCARD = 7;
    localparam logic [7:0] PS2_DISCARD [PS2_NUM_DISCARD] = '{
        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF
    };

    typedef enum logic [2:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk,
        StPause
    } ps2_state_e;

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
            if (b == PS2_DISCARD[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Fake left/right shift codes the keyboard wraps around some extended keys.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a FILTER-sample debounce on an asynchronous PS/2 line.
// Idles high; fall_o pulses for one cycle after the filtered level drops from 1 to 0.
module ps2_sync_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(FILTER + 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the run count.
        if (sync2_q != level_q) begin
            if (cnt_q == CntW'(FILTER - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_decoder.sv
// PS/2 keyboard receiver: deserialises 11-bit frames and resolves F0/E0/E1 prefixes into
// one strobe per key event. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 24000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       strobe,
    output logic [7:0] code,
    output logic       pressed,
    output logic       extended,
    output logic       error
);

    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic clk_fall, data_filt;

    ps2_sync_filter #(.FILTER(FILTER)) u_clk_filter (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (ps2_clk),
        .level_o (),
        .fall_o  (clk_fall)
    );

    ps2_sync_filter #(.FILTER(FILTER)) u_data_filter (
        .clock   (clock),
        .reset   (reset),
        .raw_i   (ps2_data),
        .level_o (data_filt),
        .fall_o  ()
    );

    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           start_bad_q, start_bad_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           timeout, frame_done, frame_err, byte_valid;
`ifdef PS2_PARITY_CHECK_EN
    logic           par_bad_q, par_bad_d;
`endif

    ps2_state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       emit, emit_pressed, emit_ext;

    logic       strobe_q, strobe_d, error_q, error_d;
    logic       pressed_q, pressed_d, extended_q, extended_d;
    logic [7:0] code_q, code_d;

    assign timeout = (to_cnt_q == ToW'(TIMEOUT));

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        start_bad_d = start_bad_q;
        to_cnt_d    = '0;
        frame_done  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_bad_d   = par_bad_q;
`endif
        // An abandoned frame also swallows a falling edge landing on the same cycle.
        if (timeout) begin
            bit_cnt_d = '0;
        end else if (clk_fall) begin
            if (bit_cnt_q == 4'd0) begin
                start_bad_d = data_filt;
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d = {data_filt, shift_q[7:1]};
`ifdef PS2_PARITY_CHECK_EN
            end else if (bit_cnt_q == 4'd9) begin
                par_bad_d = ((^shift_q) == data_filt);
`endif
            end else if (bit_cnt_q == 4'd10) begin
                frame_done = 1'b1;
            end
            bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
        end else if (bit_cnt_q != 4'd0) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_err = start_bad_q | ~data_filt | par_bad_q;
`else
    assign frame_err = start_bad_q | ~data_filt;
`endif
    assign byte_valid = frame_done & ~frame_err;

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        emit         = 1'b0;
        emit_pressed = 1'b0;
        emit_ext     = 1'b0;
        if (timeout) begin
            state_d = StIdle;
            skip_d  = '0;
        end else if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (shift_q == PS2_BREAK) begin
                        state_d = StBrk;
                    end else if (shift_q == PS2_EXT) begin
                        state_d = StExt;
                    end else if (shift_q == PS2_PAUSE) begin
                        state_d = StPause;
                        skip_d  = PS2_PAUSE_SKIP;
                    end else begin
                        emit = ~is_discard(shift_q);
                    end
                end
                StExt: begin
                    if (shift_q == PS2_BREAK) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d  = StIdle;
                        emit     = ~is_fake_shift(shift_q);
                        emit_ext = 1'b1;
                    end
                end
                StBrk: begin
                    state_d      = StIdle;
                    emit         = 1'b1;
                    emit_pressed = 1'b1;
                end
                StExtBrk: begin
                    state_d      = StIdle;
                    emit         = ~is_fake_shift(shift_q);
                    emit_pressed = 1'b1;
                    emit_ext     = 1'b1;
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        strobe_d   = emit;
        error_d    = frame_done & frame_err;
        code_d     = emit ? shift_q : code_q;
        pressed_d  = emit ? emit_pressed : pressed_q;
        extended_d = emit ? emit_ext : extended_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            start_bad_q <= 1'b0;
            to_cnt_q    <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bad_q   <= 1'b0;
`endif
            state_q     <= StIdle;
            skip_q      <= '0;
            strobe_q    <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= 8'h00;
            pressed_q   <= 1'b1;
            extended_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            start_bad_q <= start_bad_d;
            to_cnt_q    <= to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
            par_bad_q   <= par_bad_d;
`endif
            state_q     <= state_d;
            skip_q      <= skip_d;
            strobe_q    <= strobe_d;
            error_q     <= error_d;
            code_q      <= code_d;
            pressed_q   <= pressed_d;
            extended_q  <= extended_d;
        end
    end

    assign strobe   = strobe_q;
    assign error    = error_q;
    assign code     = code_q;
    assign pressed  = pressed_q;
    assign extended = extended_q;

endmodule

// File: tb/tb_ps2_decoder.sv
// Scoreboard bench for ps2_decoder: directed PS/2 frames push expected events into a queue,
// a negedge monitor pops and compares every strobe/error the decoder raises.
module tb_ps2_decoder;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 24000;
    localparam int unsigned HALF    = 20;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       strobe, pressed, extended, error;
    logic [7:0] code;

    ps2_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .strobe   (strobe),
        .code     (code),
        .pressed  (pressed),
        .extended (extended),
        .error    (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_fall_cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic ev_t key(input logic [7:0] c, input logic p, input logic x);
        ev_t r;
        r.is_err  = 1'b0;
        r.code    = c;
        r.pressed = p;
        r.ext     = x;
        return r;
    endfunction

    function automatic ev_t err_ev();
        ev_t r;
        r = '0;
        r.is_err = 1'b1;
        return r;
    endfunction

    // {stop, parity, data[7:0], start}; odd parity unless bad_par.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par,
                                          input logic bad_start, input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, bad_start};
    endfunction

    task automatic send_raw(input logic [10:0] f, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                repeat (8) @(negedge clock);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clock);
                ps2_clk = 1'b1;
                repeat (HALF - 11) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(frame(b, 1'b0, 1'b0, 1'b0), 11, -1);
    endtask

    always @(negedge clock) begin
        ev_t act;
        ev_t exp_ev;
        if (strobe || error) begin
            act.is_err  = error;
            act.code    = code;
            act.pressed = pressed;
            act.ext     = extended;
            check("latency", cyc - last_fall_cyc, FILTER + 3);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got %0h required none", act);
            end else begin
                exp_ev = exp_q.pop_front();
                if (exp_ev.is_err) check("error_event", {strobe, error}, 2'b01);
                else check("key_event", {strobe, error, act}, {2'b10, exp_ev});
            end
        end
    end

    initial begin
        repeat (5) @(negedge clock);
        check("rst_strobe", strobe, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_code", code, 8'h00);
        check("rst_pressed", pressed, 1'b1);
        check("rst_extended", extended, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        exp_q.push_back(key(8'h1C, 1'b0, 1'b0));
        send(8'h1C);

        exp_q.push_back(key(8'h1C, 1'b1, 1'b0));
        send(8'hF0); send(8'h1C);

        exp_q.push_back(key(8'h75, 1'b0, 1'b1));
        send(8'hE0); send(8'h75);
        exp_q.push_back(key(8'h75, 1'b1, 1'b1));
        send(8'hE0); send(8'hF0); send(8'h75);

        // Controller response and fake shifts vanish; the following key is a plain make.
        exp_q.push_back(key(8'h66, 1'b0, 1'b0));
        send(8'hFA); send(8'hE0); send(8'h12); send(8'hE0); send(8'hF0); send(8'h59);
        send(8'h66);

`ifdef PS2_PARITY_CHECK_EN
        exp_q.push_back(err_ev());
`else
        exp_q.push_back(key(8'h16, 1'b0, 1'b0));
`endif
        send_raw(frame(8'h16, 1'b1, 1'b0, 1'b0), 11, -1);
        exp_q.push_back(key(8'h16, 1'b0, 1'b0));
        send(8'h16);

        exp_q.push_back(err_ev());
        send_raw(frame(8'h21, 1'b0, 1'b1, 1'b0), 11, -1);
        exp_q.push_back(err_ev());
        send_raw(frame(8'h22, 1'b0, 1'b0, 1'b1), 11, -1);

        exp_q.push_back(key(8'h5A, 1'b0, 1'b0));
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'hAA); send(8'h5A);

        exp_q.push_back(key(8'h4B, 1'b0, 1'b0));
        send_raw(frame(8'h4B, 1'b0, 1'b0, 1'b0), 11, 3);

        exp_q.push_back(key(8'h29, 1'b0, 1'b0));
        send_raw(frame(8'h29, 1'b0, 1'b0, 1'b0), 5, -1);
        repeat (TIMEOUT + 10) @(negedge clock);
        send(8'h29);

        // Reset mid-frame with the FSM in BRK: both the frame and the prefix are lost.
        send(8'hF0);
        send_raw(frame(8'h3A, 1'b0, 1'b0, 1'b0), 4, -1);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_pressed", pressed, 1'b1);
        check("midrst_code", code, 8'h00);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        exp_q.push_back(key(8'h3A, 1'b0, 1'b0));
        send(8'h3A);

        repeat (50) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_decoder.md
# ps2_decoder

Receives the raw PS/2 keyboard clock/data lines, deserialises 11-bit frames, and resolves the scan-code set 2 prefixes (F0 break, E0 extended, E1 pause) into one event per key transition. It feeds the `keyboard` matrix block directly, using its `strobe`/`code`/`pressed` contract, with `pressed` active-low: 0 = make, 1 = break. Controller responses and pause sequences are absorbed here, so the matrix never sees them.

## Interface
- `FILTER`, 8: consecutive identical samples required before the synchronised `ps2_clk` level is accepted.
- `TIMEOUT`, 24000: clock cycles without a filtered falling edge before a partial frame is abandoned.
- `clock` in 1: system clock; everything is in this domain.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `strobe` out 1: one-cycle pulse, one per resolved key event.
- `code` out 8: scan code with prefixes stripped.
- `pressed` out 1: 0 = make, 1 = break (matrix key bits are active-low).
- `extended` out 1: 1 if the event was E0-prefixed.
- `error` out 1: one-cycle pulse on a framing or parity error.

## Operation
- Sync/filter:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The filtered clock changes only after `FILTER` equal samples.
  - A filtered 1→0 transition is a falling edge; data is sampled on that cycle.
- Frame receive, bit counter 0..10:
  - Bit 0 is the start bit and must be 0.
  - Bits 1..8 are data, LSB first.
  - Bit 9 is odd parity.
  - Bit 10 is the stop bit and must be 1.
- Frame result:
  - Bad start or stop bit: `error` pulses and the byte is dropped.
  - The counter returns to 0 after bit 10 in every case.
- Timeout counter:
  - Cleared on every filtered falling edge and held at 0 while the bit counter is 0.
  - On reaching `TIMEOUT`, the bit counter and prefix state return to idle.
  - A timeout produces no `error` pulse.
- Prefix FSM, states `IDLE`, `BRK`, `EXT`, `EXT_BRK`, `PAUSE`:
  - `IDLE`: F0→`BRK`; E0→`EXT`; E1→`PAUSE` with the skip counter = 7.
  - `IDLE`: FA, AA, EE, FE, FC, 00, FF are discarded and the FSM stays in `IDLE`.
  - `IDLE`, any other byte: emit with pressed=0, extended=0.
  - `EXT`: F0→`EXT_BRK`; 12 or 59 (fake shift) is discarded →`IDLE`; otherwise emit pressed=0, extended=1 →`IDLE`.
  - `BRK`: emit pressed=1, extended=0 →`IDLE`.
  - `EXT_BRK`: 12 or 59 is discarded →`IDLE`; otherwise emit pressed=1, extended=1 →`IDLE`.
  - `PAUSE`: every byte decrements the skip counter; at 0 →`IDLE`. No event is emitted.
- Emit: `code`, `pressed`, `extended` update on the same edge that raises `strobe`. They hold until the next emit.
- Bad-parity byte (when checked): it is not fed to the FSM, and the FSM state is unchanged.

## Timing
- Reset values: `strobe`=0, `error`=0, `code`=8'h00, `pressed`=1, `extended`=0.
- Reset state: FSM `IDLE`, counters 0, filtered clock = 1.
- Event latency: `strobe` rises exactly `FILTER`+3 clocks after the raw stop-bit falling edge of `ps2_clk`.
- `strobe` and `error` are never high together, and never high for more than one cycle.
- Back-to-back frames: the FSM consumes one byte per frame with no stall. No backpressure exists, so the consumer must accept every `strobe`.
- Asserting reset mid-frame aborts the frame. Reception restarts at the next start bit after release.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity mismatch pulses `error` and drops the byte.
- Undefined: the parity bit is sampled but ignored, and the byte is processed normally.

## Structure
- Package `ps2_pkg` holds:
  - prefix constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_PAUSE`=8'hE1;
  - the discard-code list;
  - the FSM state enum.
- Sub-module `ps2_sync_filter`, instantiated twice (clock and data): 2-FF synchroniser plus `FILTER`-sample debounce. It outputs the filtered level, and a falling-edge pulse for the clock instance.

## Test plan
- Frame 1C → one `strobe`; `code`=1C, `pressed`=0, `extended`=0.
- Frames F0,1C → exactly one `strobe`; `code`=1C, `pressed`=1.
- Frames E0,75 then E0,F0,75 → two strobes; both `code`=75 and `extended`=1; `pressed`=0 then 1.
- With `PS2_PARITY_CHECK_EN` defined, frame 16 with even parity → `error` pulse, no `strobe`. The next valid frame 16 → `strobe`, `code`=16.
- 5 bits, then idle for `TIMEOUT`+10 cycles, then full frame 29 → no `error`; one `strobe` with `code`=29.
- E1,14,77,E1,F0,14,F0,77 then AA then frame 5A → exactly one `strobe`, with `code`=5A and `pressed`=0.
- A 3-cycle glitch low on `ps2_clk` (with `FILTER`=8) → no bit sampled; the frame still decodes correctly.
